// File: rtl/cr_io_pkg.sv
// Shared definitions for the CR-CPU I/O peripherals: register select
// constants and default sizing for the input port.
package cr_io_pkg;

  localparam logic ADDR_LEVEL = 1'b0;
  localparam logic ADDR_EVENT = 1'b1;

  localparam int DEFAULT_WIDTH          = 8;
  localparam int DEFAULT_PRESCALE       = 16000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 5;

endpackage

// File: rtl/debounce_bit.sv
// One input pin: two-stage synchroniser followed by a tick-driven debounce
// counter that accepts a new level only after it persists for DEBOUNCE_TICKS ticks.
module debounce_bit
  import cr_io_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  input  logic i_tick,
  output logic o_lvl,
  output logic o_rise
);

  localparam int              CW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (s2 != lvl) && i_tick && (cnt == CNT_LAST);

  // Any cycle where the synchronised pin agrees with lvl restarts the window,
  // so a glitch shorter than the window never reaches lvl.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= i_pin;
      s2 <= s1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (accept) begin
        lvl <= s2;
        cnt <= '0;
      end else if (i_tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_lvl  = lvl;
  assign o_rise = accept && s2;

endmodule

// File: rtl/gpio_input_port.sv
// Debounced 8-bit input port for the CR-CPU: level and sticky rising-edge
// event registers behind a one-cycle-latency read port, plus a masked interrupt.
module gpio_input_port
  import cr_io_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int PRESCALE       = DEFAULT_PRESCALE,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_pins,
  input  logic             i_rd_en,
  input  logic             i_addr,
  input  logic [WIDTH-1:0] i_irq_mask,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_irq
);

  logic             tick;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] event_q;
  logic [WIDTH-1:0] clr;

  // Free-running prescaler shared by all bits; never restarted by pin activity.
  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int            PW       = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
          pre_cnt <= '0;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end

      assign tick = (pre_cnt == PRE_LAST);
    end
  endgenerate

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_pin   (i_pins[b]),
      .i_tick  (tick),
      .o_lvl   (level[b]),
      .o_rise  (rise[b])
    );
  end

  assign clr = (i_rd_en && (i_addr == ADDR_EVENT)) ? event_q : '0;

  // Only flags that were visible to the read are cleared; a rise on the same
  // edge is ORed in afterwards so it is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      event_q <= '0;
    end else begin
      event_q <= (event_q & ~clr) | rise;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= (i_addr == ADDR_EVENT) ? event_q : level;
      end
    end
  end

  assign o_irq = |(event_q & i_irq_mask);

endmodule
